// File: rtl/csr_ctrl.sv
// csr_ctrl: CSR access sequencer for the write-back stage.
// Drives the CSR register file read port and both write ports to run
// CSRRW/CSRRS/CSRRC, ECALL and MRET as IDLE -> RD -> WR -> RESP sequences.
// It returns the old CSR value for rd, and a PC redirect for trap entry and return.
module csr_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_src,
  input  logic        i_rs1_zero,
  input  logic [31:0] i_pc,
  output logic [11:0] o_csr_raddr,
  input  logic [31:0] i_csr_rdata,
  output logic [11:0] o_csr_waddr1,
  output logic [31:0] o_csr_wdata1,
  output logic        o_csr_wena1,
  output logic [11:0] o_csr_waddr2,
  output logic [31:0] o_csr_wdata2,
  output logic        o_csr_wena2,
  output logic        o_done,
  output logic [31:0] o_rd_data,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_illegal
);

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [31:0] CAUSE_ECALL = 32'd11;

  localparam logic [2:0] OP_RW    = 3'b001;
  localparam logic [2:0] OP_RS    = 3'b010;
  localparam logic [2:0] OP_RC    = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q;
  logic        rs1_zero_q;
  logic [31:0] pc_q;
  logic [31:0] old_q;

  logic        is_csr_op;
  logic        is_ecall;
  logic        is_mret;
  logic        is_legal_op;
  logic        wants_write;
  logic        ro_write;
  logic [31:0] csr_new;

  // Decode the latched request; a read-only CSR only counts as illegal when a write is actually attempted.
  assign is_csr_op   = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);
  assign is_ecall    = (op_q == OP_ECALL);
  assign is_mret     = (op_q == OP_MRET);
  assign is_legal_op = is_csr_op || is_ecall || is_mret;
  assign wants_write = (op_q == OP_RW) || !rs1_zero_q;
  assign ro_write    = is_csr_op && (addr_q[11:10] == 2'b11) && wants_write;

  // New CSR value for the read-modify-write ops.
  always_comb begin
    csr_new = 32'd0;
    case (op_q)
      OP_RW:   csr_new = src_q;
      OP_RS:   csr_new = old_q | src_q;
      OP_RC:   csr_new = old_q & ~src_q;
      default: csr_new = 32'd0;
    endcase
  end

  // State register; reset returns to IDLE asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Request fields are captured on acceptance; the old CSR value is captured at the end of RD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q       <= 3'd0;
      addr_q     <= 12'd0;
      src_q      <= 32'd0;
      rs1_zero_q <= 1'b0;
      pc_q       <= 32'd0;
      old_q      <= 32'd0;
    end else if (state_q == ST_IDLE && i_valid) begin
      op_q       <= i_op;
      addr_q     <= i_csr_addr;
      src_q      <= i_src;
      rs1_zero_q <= i_rs1_zero;
      pc_q       <= i_pc;
    end else if (state_q == ST_RD) begin
      old_q      <= is_legal_op ? i_csr_rdata : 32'd0;
    end
  end

  // Next state and all outputs, decoded only from the state and latched registers.
  always_comb begin
    state_d       = state_q;
    o_ready       = 1'b0;
    o_csr_raddr   = 12'd0;
    o_csr_waddr1  = 12'd0;
    o_csr_wdata1  = 32'd0;
    o_csr_wena1   = 1'b0;
    o_csr_waddr2  = 12'd0;
    o_csr_wdata2  = 32'd0;
    o_csr_wena2   = 1'b0;
    o_done        = 1'b0;
    o_rd_data     = 32'd0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'd0;
    o_illegal     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = ST_RD;
      end
      ST_RD: begin
        if (is_csr_op)     o_csr_raddr = addr_q;
        else if (is_ecall) o_csr_raddr = ADDR_MTVEC;
        else if (is_mret)  o_csr_raddr = ADDR_MEPC;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (is_csr_op && wants_write && !ro_write) begin
          o_csr_wena1  = 1'b1;
          o_csr_waddr1 = addr_q;
          o_csr_wdata1 = csr_new;
        end else if (is_ecall) begin
          o_csr_wena1  = 1'b1;
          o_csr_waddr1 = ADDR_MEPC;
          o_csr_wdata1 = pc_q;
          o_csr_wena2  = 1'b1;
          o_csr_waddr2 = ADDR_MCAUSE;
          o_csr_wdata2 = CAUSE_ECALL;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        o_done    = 1'b1;
        o_illegal = !is_legal_op || ro_write;
        if (is_csr_op) o_rd_data = old_q;
        if (is_ecall) begin
          o_redirect    = 1'b1;
          o_redirect_pc = old_q & ~32'h3;
        end else if (is_mret) begin
          o_redirect    = 1'b1;
          o_redirect_pc = old_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: directed and randomized checks of csr_ctrl against a CSR-file model.
module tb_csr_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic [11:0] i_csr_addr = 12'd0;
  logic [31:0] i_src = 32'd0;
  logic        i_rs1_zero = 1'b0;
  logic [31:0] i_pc = 32'd0;
  logic [11:0] o_csr_raddr;
  logic [31:0] i_csr_rdata;
  logic [11:0] o_csr_waddr1, o_csr_waddr2;
  logic [31:0] o_csr_wdata1, o_csr_wdata2;
  logic        o_csr_wena1, o_csr_wena2;
  logic        o_done;
  logic [31:0] o_rd_data;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  // Register file driven by the DUT, and the model's own view of CSR contents.
  logic [31:0] rf  [0:4095];
  logic [31:0] mdl [0:4095];

  csr_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_csr_addr(i_csr_addr), .i_src(i_src), .i_rs1_zero(i_rs1_zero),
    .i_pc(i_pc), .o_csr_raddr(o_csr_raddr), .i_csr_rdata(i_csr_rdata),
    .o_csr_waddr1(o_csr_waddr1), .o_csr_wdata1(o_csr_wdata1), .o_csr_wena1(o_csr_wena1),
    .o_csr_waddr2(o_csr_waddr2), .o_csr_wdata2(o_csr_wdata2), .o_csr_wena2(o_csr_wena2),
    .o_done(o_done), .o_rd_data(o_rd_data), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // The register file: combinational read port, two write ports committing on the rising edge.
  assign i_csr_rdata = rf[o_csr_raddr];

  always @(posedge i_clk) begin
    if (o_csr_wena1) rf[o_csr_waddr1] <= o_csr_wdata1;
    if (o_csr_wena2) rf[o_csr_waddr2] <= o_csr_wdata2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"},  {31'd0, o_ready}, 32'd1);
    checkOutput({tag, "_raddr"},  {20'd0, o_csr_raddr}, 32'd0);
    checkOutput({tag, "_wena1"},  {31'd0, o_csr_wena1}, 32'd0);
    checkOutput({tag, "_wena2"},  {31'd0, o_csr_wena2}, 32'd0);
    checkOutput({tag, "_wport"},  {20'd0, o_csr_waddr1} | o_csr_wdata1 | {20'd0, o_csr_waddr2} | o_csr_wdata2, 32'd0);
    checkOutput({tag, "_done"},   {31'd0, o_done}, 32'd0);
    checkOutput({tag, "_redir"},  {31'd0, o_redirect}, 32'd0);
    checkOutput({tag, "_ill"},    {31'd0, o_illegal}, 32'd0);
    checkOutput({tag, "_rdpc"},   o_rd_data | o_redirect_pc, 32'd0);
  endtask

  // Runs one request through the sequencer, predicting every phase from the CSR model.
  // hold keeps i_valid high after acceptance; rst_wr asserts reset in the WR cycle.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [11:0] addr,
                               input logic [31:0] src, input logic rs1z, input logic [31:0] pc,
                               input bit hold, input bit rst_wr);
    logic [11:0] e_raddr = 12'd0;
    logic [31:0] e_old = 32'd0, e_rd = 32'd0, e_rpc = 32'd0, e_new = 32'd0;
    logic        e_ill = 1'b0, e_redir = 1'b0, e_we1 = 1'b0, e_we2 = 1'b0;
    logic [11:0] e_a1 = 12'd0, e_a2 = 12'd0;
    logic [31:0] e_d1 = 32'd0, e_d2 = 32'd0;
    bit read_only = (addr[11:10] == 2'b11);
    bit writes    = (op == 3'b001) || !rs1z;

    case (op)
      3'b001, 3'b010, 3'b011: begin
        e_raddr = addr;
        e_old   = mdl[addr];
        e_rd    = e_old;
        e_new   = (op == 3'b001) ? src : (op == 3'b010) ? (e_old | src) : (e_old & ~src);
        e_ill   = read_only && writes;
        if (writes && !read_only) begin
          e_we1 = 1'b1; e_a1 = addr; e_d1 = e_new;
        end
      end
      3'b100: begin
        e_raddr = 12'h305;
        e_old   = mdl[12'h305];
        e_we1 = 1'b1; e_a1 = 12'h341; e_d1 = pc;
        e_we2 = 1'b1; e_a2 = 12'h342; e_d2 = 32'd11;
        e_redir = 1'b1;
        e_rpc   = e_old & ~32'h3;
      end
      3'b101: begin
        e_raddr = 12'h341;
        e_redir = 1'b1;
        e_rpc   = mdl[12'h341];
      end
      default: e_ill = 1'b1;
    endcase

    @(negedge i_clk);
    checkOutput({tag, "_idle_ready"}, {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1; i_op = op; i_csr_addr = addr; i_src = src; i_rs1_zero = rs1z; i_pc = pc;

    @(negedge i_clk);
    i_valid = hold; i_op = 3'($urandom); i_csr_addr = 12'($urandom);
    i_src = $urandom; i_rs1_zero = 1'($urandom); i_pc = $urandom;
    checkOutput({tag, "_rd_ready"}, {31'd0, o_ready}, 32'd0);
    checkOutput({tag, "_rd_raddr"}, {20'd0, o_csr_raddr}, {20'd0, e_raddr});
    checkOutput({tag, "_rd_wena"}, {30'd0, o_csr_wena2, o_csr_wena1}, 32'd0);
    checkOutput({tag, "_rd_done"}, {31'd0, o_done}, 32'd0);

    @(negedge i_clk);
    checkOutput({tag, "_wr_ready"}, {31'd0, o_ready}, 32'd0);
    checkOutput({tag, "_wr_wena1"}, {31'd0, o_csr_wena1}, {31'd0, e_we1});
    checkOutput({tag, "_wr_waddr1"}, {20'd0, o_csr_waddr1}, {20'd0, e_a1});
    checkOutput({tag, "_wr_wdata1"}, o_csr_wdata1, e_d1);
    checkOutput({tag, "_wr_wena2"}, {31'd0, o_csr_wena2}, {31'd0, e_we2});
    checkOutput({tag, "_wr_waddr2"}, {20'd0, o_csr_waddr2}, {20'd0, e_a2});
    checkOutput({tag, "_wr_wdata2"}, o_csr_wdata2, e_d2);
    checkOutput({tag, "_wr_done"}, {31'd0, o_done}, 32'd0);

    if (rst_wr) begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      #1;
      checkResetOutputs({tag, "_rst"});
      @(negedge i_clk);
      checkResetOutputs({tag, "_rsthold"});
      i_rst_n = 1'b1;
      checkOutput({tag, "_rst_mepc"}, rf[12'h341], mdl[12'h341]);
      checkOutput({tag, "_rst_mcause"}, rf[12'h342], mdl[12'h342]);
      return;
    end

    @(negedge i_clk);
    checkOutput({tag, "_resp_done"}, {31'd0, o_done}, 32'd1);
    checkOutput({tag, "_resp_ready"}, {31'd0, o_ready}, 32'd0);
    checkOutput({tag, "_resp_rd"}, o_rd_data, e_rd);
    checkOutput({tag, "_resp_redir"}, {31'd0, o_redirect}, {31'd0, e_redir});
    checkOutput({tag, "_resp_rpc"}, o_redirect_pc, e_rpc);
    checkOutput({tag, "_resp_ill"}, {31'd0, o_illegal}, {31'd0, e_ill});
    checkOutput({tag, "_resp_wena"}, {30'd0, o_csr_wena2, o_csr_wena1}, 32'd0);

    @(negedge i_clk);
    i_valid = 1'b0;
    checkOutput({tag, "_back_ready"}, {31'd0, o_ready}, 32'd1);
    checkOutput({tag, "_back_done"}, {31'd0, o_done}, 32'd0);

    if (e_we1) mdl[e_a1] = e_d1;
    if (e_we2) mdl[e_a2] = e_d2;
    checkOutput({tag, "_rf_addr"}, rf[addr], mdl[addr]);
    checkOutput({tag, "_rf_mepc"}, rf[12'h341], mdl[12'h341]);
    checkOutput({tag, "_rf_mcause"}, rf[12'h342], mdl[12'h342]);
  endtask

  initial begin
    logic [2:0]  ops   [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110, 3'b111};
    logic [11:0] addrs [6] = '{12'h305, 12'h341, 12'h342, 12'h300, 12'hF11, 12'hC00};

    for (int i = 0; i < 4096; i++) begin
      rf[i]  = 32'd0;
      mdl[i] = 32'd0;
    end
    rf[12'hF11]  = 32'h7973_7978;
    mdl[12'hF11] = 32'h7973_7978;
    rf[12'hF12]  = 32'h0000_0023;
    mdl[12'hF12] = 32'h0000_0023;

    $display("[TB] reset phase");
    #2;
    checkResetOutputs("reset");
    repeat (2) @(negedge i_clk);
    checkResetOutputs("reset_held");
    i_rst_n = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus("rw_mtvec", 3'b001, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("rs_zero",  3'b010, 12'h305, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus("rw_mepc",  3'b001, 12'h341, 32'hFFFF_00F0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("rc_mepc",  3'b011, 12'h341, 32'h0000_00F0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rc_mepc_value", rf[12'h341], 32'hFFFF_0000);
    applyStimulus("rw_mtvec2", 3'b001, 12'h305, 32'h8000_0103, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("ecall",    3'b100, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 1'b0, 1'b0);
    checkOutput("ecall_mcause", rf[12'h342], 32'd11);
    applyStimulus("mret",     3'b101, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("rw_ro",    3'b001, 12'hF11, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus("rs_ro_z",  3'b010, 12'hF12, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus("rs_ro_w",  3'b010, 12'hF12, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("op111",    3'b111, 12'h305, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("hold",     3'b010, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("rst_wr",   3'b100, 12'h000, 32'h0, 1'b0, 32'h1234_5670, 1'b0, 1'b1);
    applyStimulus("post_rst", 3'b101, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  r_op   = ops[$urandom_range(0, 7)];
      logic [11:0] r_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 5)];
      logic        r_z    = ($urandom_range(0, 3) == 0);
      logic [31:0] r_src  = r_z ? 32'd0 : $urandom;
      applyStimulus($sformatf("rnd%0d", n), r_op, r_addr, r_src, r_z, $urandom, bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
